// File: rtl/cr_tie_monitor.sv
// cr_tie_monitor: consumer-side integrity monitor for a tie-cell constant pair.
// Resynchronises tie_o / tie_ob, debounces any deviation from (1, 0) and raises
// a level interrupt with sticky status, OR-accumulated type and a saturating count.
module cr_tie_monitor #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             tie_o,
  input  logic             tie_ob,
  input  logic             clr_err,
  input  logic             err_ack,
  output logic             err_irq,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       err_type,
  output logic             busy
);

  localparam int unsigned DW = $clog2(DEBOUNCE + 1);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] CHECK = 2'b01;
  localparam logic [1:0] FAULT = 2'b10;

  logic             o_q1, o_q2, ob_q1, ob_q2;
  logic [1:0]       mm;
  logic             mm_any;

  logic [1:0]       state, state_nx;
  logic [DW-1:0]    deb_cnt, deb_nx;
  logic             irq_nx, sticky_nx, busy_nx, fault_entry;
  logic [CNT_W-1:0] cnt_nx;
  logic [1:0]       type_nx;

  // Two-flop synchronisers, reset to the expected tie values so reset is clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q1  <= 1'b1;
      o_q2  <= 1'b1;
      ob_q1 <= 1'b0;
      ob_q2 <= 1'b0;
    end else begin
      o_q1  <= tie_o;
      o_q2  <= o_q1;
      ob_q1 <= tie_ob;
      ob_q2 <= ob_q1;
    end
  end

  assign mm     = {ob_q2, ~o_q2};
  assign mm_any = |mm;

  // State, debounce counter and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      deb_cnt    <= '0;
      err_irq    <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      err_type   <= 2'b00;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      deb_cnt    <= deb_nx;
      err_irq    <= irq_nx;
      err_sticky <= sticky_nx;
      err_cnt    <= cnt_nx;
      err_type   <= type_nx;
      busy       <= busy_nx;
    end
  end

  // Next-state and next-output logic; a fault entry overrides a same-cycle clear.
  always_comb begin
    state_nx    = state;
    deb_nx      = '0;
    irq_nx      = err_irq;
    sticky_nx   = clr_err ? 1'b0  : err_sticky;
    cnt_nx      = clr_err ? '0    : err_cnt;
    type_nx     = clr_err ? 2'b00 : err_type;
    fault_entry = 1'b0;

    case (state)
      IDLE: begin
        if (enable) state_nx = CHECK;
      end
      CHECK: begin
        if (!enable) begin
          state_nx = IDLE;
        end else if (mm_any) begin
          if (deb_cnt == DW'(DEBOUNCE - 1)) begin
            state_nx    = FAULT;
            fault_entry = 1'b1;
          end else begin
            deb_nx = deb_cnt + DW'(1);
          end
        end
      end
      FAULT: begin
        if (err_ack) begin
          irq_nx   = 1'b0;
          state_nx = enable ? CHECK : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (fault_entry) begin
      irq_nx    = 1'b1;
      sticky_nx = 1'b1;
      type_nx   = type_nx | mm;
      if (cnt_nx != {CNT_W{1'b1}}) cnt_nx = cnt_nx + CNT_W'(1);
    end

    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_cr_tie_monitor.sv
// Self-checking bench for cr_tie_monitor (DEBOUNCE = 4, CNT_W = 2).
// Expected output vectors {irq, sticky, cnt[1:0], type[1:0], busy} are queued
// when stimulus is applied and popped for comparison when the DUT is sampled.
module tb_cr_tie_monitor;

  localparam int unsigned DEBOUNCE = 4;
  localparam int unsigned CNT_W    = 2;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             tie_o;
  logic             tie_ob;
  logic             clr_err;
  logic             err_ack;
  logic             err_irq;
  logic             err_sticky;
  logic [CNT_W-1:0] err_cnt;
  logic [1:0]       err_type;
  logic             busy;

  typedef struct {
    string      name;
    logic [6:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total  = 0;
  int   passed = 0;

  cr_tie_monitor #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .tie_o      (tie_o),
    .tie_ob     (tie_ob),
    .clr_err    (clr_err),
    .err_ack    (err_ack),
    .err_irq    (err_irq),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .err_type   (err_type),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clock edges; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string n, input logic [6:0] v);
    exp_t x;
    x.name = n;
    x.val  = v;
    sb.push_back(x);
  endtask

  task automatic test_reset;
    logic [6:0] obs;
    rst = 1'b1; enable = 1'b0; tie_o = 1'b1; tie_ob = 1'b0;
    clr_err = 1'b0; err_ack = 1'b0;
    push_exp("reset_state", 7'b0_0_00_00_0);
    step(2);
    e = sb.pop_front(); total++;
    obs = {err_irq, err_sticky, err_cnt, err_type, busy};
    if (obs !== e.val) $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    else passed++;
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_clean_run;
    logic [6:0] obs;
    enable = 1'b1;
    push_exp("clean_busy_first_edge", 7'b0_0_00_00_1);
    step(1);
    e = sb.pop_front(); total++;
    obs = {err_irq, err_sticky, err_cnt, err_type, busy};
    if (obs !== e.val) $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    else passed++;
    push_exp("clean_1000_cycles", 7'b0_0_00_00_1);
    step(1000);
    e = sb.pop_front(); total++;
    obs = {err_irq, err_sticky, err_cnt, err_type, busy};
    if (obs !== e.val) $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    else passed++;
  endtask

  task automatic test_fault_latency;
    logic [6:0] obs;
    tie_o = 1'b0;
    push_exp("latency_no_irq_at_k4", 7'b0_0_00_00_1);
    push_exp("latency_irq_at_k5",    7'b1_1_01_01_1);
    push_exp("fault_held_no_ack",    7'b1_1_01_01_1);
    push_exp("ack_returns_check",    7'b0_1_01_01_1);
    push_exp("clr_after_fault",      7'b0_0_00_00_1);
    step(5);
    e = sb.pop_front(); total++;
    obs = {err_irq, err_sticky, err_cnt, err_type, busy};
    if (obs !== e.val) $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    else passed++;
    step(1);
    e = sb.pop_front(); total++;
    obs = {err_irq, err_sticky, err_cnt, err_type, busy};
    if (obs !== e.val) $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    else passed++;
    tie_o = 1'b1;
    step(3);
    e = sb.pop_front(); total++;
    obs = {err_irq, err_sticky, err_cnt, err_type, busy};
    if (obs !== e.val) $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    else passed++;
    err_ack = 1'b1;
    step(1);
    err_ack = 1'b0;
    e = sb.pop_front(); total++;
    obs = {err_irq, err_sticky, err_cnt, err_type, busy};
    if (obs !== e.val) $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    else passed++;
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    e = sb.pop_front(); total++;
    obs = {err_irq, err_sticky, err_cnt, err_type, busy};
    if (obs !== e.val) $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    else passed++;
  endtask

  task automatic test_glitch;
    logic [6:0] obs;
    push_exp("glitch_no_fault",       7'b0_0_00_00_1);
    push_exp("glitch_no_fault_later", 7'b0_0_00_00_1);
    for (int i = 0; i < 10; i++) begin
      tie_ob = 1'b1;
      step(3);
      tie_ob = 1'b0;
      step(3);
    end
    e = sb.pop_front(); total++;
    obs = {err_irq, err_sticky, err_cnt, err_type, busy};
    if (obs !== e.val) $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    else passed++;
    step(4);
    e = sb.pop_front(); total++;
    obs = {err_irq, err_sticky, err_cnt, err_type, busy};
    if (obs !== e.val) $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    else passed++;
  endtask

  task automatic test_ack_disabled;
    logic [6:0] obs;
    tie_ob = 1'b1;
    push_exp("ob_fault_raised",         7'b1_1_01_10_1);
    push_exp("fault_survives_disable",  7'b1_1_01_10_1);
    push_exp("ack_disabled_to_idle",    7'b0_1_01_10_0);
    step(6);
    e = sb.pop_front(); total++;
    obs = {err_irq, err_sticky, err_cnt, err_type, busy};
    if (obs !== e.val) $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    else passed++;
    enable = 1'b0;
    tie_ob = 1'b0;
    step(3);
    e = sb.pop_front(); total++;
    obs = {err_irq, err_sticky, err_cnt, err_type, busy};
    if (obs !== e.val) $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    else passed++;
    err_ack = 1'b1;
    step(1);
    err_ack = 1'b0;
    e = sb.pop_front(); total++;
    obs = {err_irq, err_sticky, err_cnt, err_type, busy};
    if (obs !== e.val) $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    else passed++;
  endtask

  task automatic test_saturation;
    logic [6:0] obs;
    logic [1:0] exp_cnt;
    clr_err = 1'b1;
    push_exp("clr_in_idle", 7'b0_0_00_00_0);
    step(1);
    clr_err = 1'b0;
    e = sb.pop_front(); total++;
    obs = {err_irq, err_sticky, err_cnt, err_type, busy};
    if (obs !== e.val) $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    else passed++;
    enable = 1'b1;
    step(1);
    for (int i = 0; i < 5; i++) begin
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      push_exp($sformatf("sat_fault_%0d", i), {1'b1, 1'b1, exp_cnt, 2'b01, 1'b1});
      tie_o = 1'b0;
      step(6);
      e = sb.pop_front(); total++;
      obs = {err_irq, err_sticky, err_cnt, err_type, busy};
      if (obs !== e.val) $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
      else passed++;
      tie_o = 1'b1;
      step(3);
      err_ack = 1'b1;
      step(1);
      err_ack = 1'b0;
      step(1);
    end
    push_exp("clr_after_saturation", 7'b0_0_00_00_1);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    e = sb.pop_front(); total++;
    obs = {err_irq, err_sticky, err_cnt, err_type, busy};
    if (obs !== e.val) $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    else passed++;
  endtask

  task automatic test_clr_coincident;
    logic [6:0] obs;
    // Prime cnt = 1, type = 01 so the coincident clear is observable.
    push_exp("prime_fault",         7'b0_1_01_01_1);
    push_exp("clr_vs_fault_entry",  7'b1_1_01_10_1);
    push_exp("rst_mid_fault_async", 7'b0_0_00_00_0);
    push_exp("rst_held",            7'b0_0_00_00_0);
    push_exp("no_pending_after_rst",7'b0_0_00_00_0);
    tie_o = 1'b0;
    step(6);
    tie_o = 1'b1;
    step(3);
    err_ack = 1'b1;
    step(1);
    err_ack = 1'b0;
    e = sb.pop_front(); total++;
    obs = {err_irq, err_sticky, err_cnt, err_type, busy};
    if (obs !== e.val) $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    else passed++;
    step(2);
    tie_ob = 1'b1;
    step(5);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    e = sb.pop_front(); total++;
    obs = {err_irq, err_sticky, err_cnt, err_type, busy};
    if (obs !== e.val) $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    else passed++;
    rst = 1'b1;
    #1;
    e = sb.pop_front(); total++;
    obs = {err_irq, err_sticky, err_cnt, err_type, busy};
    if (obs !== e.val) $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    else passed++;
    enable = 1'b0;
    tie_ob = 1'b0;
    step(2);
    e = sb.pop_front(); total++;
    obs = {err_irq, err_sticky, err_cnt, err_type, busy};
    if (obs !== e.val) $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    else passed++;
    rst = 1'b0;
    step(8);
    e = sb.pop_front(); total++;
    obs = {err_irq, err_sticky, err_cnt, err_type, busy};
    if (obs !== e.val) $display("FAIL %s: observed %b expected %b", e.name, obs, e.val);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_fault_latency();
    test_glitch();
    test_ack_disabled();
    test_saturation();
    test_clr_coincident();
    if (sb.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: observed %0d entries left expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
